cla_multiword_add_seq: RTL and testbench

//  Sequencer that time-shares one external 16-bit carry-lookahead adder to

---
 rtl/cla_multiword_add_seq_if.sv | 51 +++++
 rtl/cla_multiword_add_seq.sv | 155 +++++++++++++++
 tb/tb_cla_multiword_add_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_multiword_add_seq_if.sv
// ---------------------------------------------------------------------------
// cla_multiword_add_seq_if
// Bundles the signals of the multi-word add/subtract sequencer:
//   in_*   operand request channel (valid/ready) plus abort
//   add_*  connection to the shared external 16-bit carry-lookahead adder
//   out_*  result channel (valid/ready)
// Modports:
//   slave  - the sequencer's view
//   master - the surrounding environment's view (source, sink and adder)
// ---------------------------------------------------------------------------
interface cla_multiword_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_cin;
    logic                  in_sub;
    logic                  abort;

    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic                  add_cin;
    logic [15:0]           add_sum;
    logic                  add_cout;

    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
    logic                  out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, abort,
        input  add_sum, add_cout,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_cin,
        output out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, abort,
        output add_sum, add_cout,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_cin,
        input  out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cla_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// cla_multiword_add_seq
// Time-shares one external combinational 16-bit carry-lookahead adder to
// perform a WORDS*16-bit add (A+B+cin) or subtract (A-B-cin), one 16-bit
// slice per clock, least significant word first. The slice carry-out is
// registered and fed back as the next slice's carry-in.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - cla_multiword_add_seq_if.slave: operand request channel, abort,
//          adder connection and result channel
// Operation: IDLE (in_ready=1) -> RUN (WORDS cycles) -> DONE (out_valid=1,
// result held until out_ready) -> IDLE.
// ---------------------------------------------------------------------------
module cla_multiword_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_multiword_add_seq_if.slave  bus
);
    localparam int unsigned W    = 16 * WORDS;
    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;      // B already inverted for subtract
    logic [W-1:0]    sum_q,   sum_d;
    logic            carry_q, carry_d;
    logic            cout_q,  cout_d;
    logic            ovf_q,   ovf_d;

    logic [15:0]     a_slice;
    logic [15:0]     b_slice;
    logic            last_slice;

    // Current slice of the latched operands.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_slice = a_q[16*i +: 16];
                b_slice = b_q[16*i +: 16];
            end
        end
    end

    assign last_slice = (idx_q == LAST_IDX);

    // Adder inputs are forced to zero outside RUN so they never carry stale data.
    assign bus.add_a     = (state_q == RUN) ? a_slice : '0;
    assign bus.add_b     = (state_q == RUN) ? b_slice : '0;
    assign bus.add_cin   = (state_q == RUN) ? carry_q : 1'b0;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                // abort is ignored here, so a simultaneous request is accepted.
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    // Subtract as A + ~B + 1; a borrow-in removes the +1.
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_cin ^ bus.in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (bus.abort) begin
                    // Drop the partial result so it is never presented.
                    state_d = IDLE;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    for (int unsigned i = 0; i < WORDS; i++) begin
                        if (idx_q == IDXW'(i)) begin
                            sum_d[16*i +: 16] = bus.add_sum;
                        end
                    end
                    carry_d = bus.add_cout;
                    if (last_slice) begin
                        cout_d  = bus.add_cout;
                        // Signed overflow: equal operand signs, different result sign.
                        ovf_d   = (a_slice[15] == b_slice[15]) &&
                                  (bus.add_sum[15] != a_slice[15]);
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_multiword_add_seq
// Directed bench for the multi-word add/subtract sequencer. A WORDS=4 and a
// WORDS=1 instance share clk/rst; each is paired with a combinational 16-bit
// adder model standing in for the external carry-lookahead adder.
// ---------------------------------------------------------------------------
module tb_cla_multiword_add_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_multiword_add_seq_if #(.WORDS(4)) bus  ();
    cla_multiword_add_seq_if #(.WORDS(1)) bus1 ();

    cla_multiword_add_seq #(.WORDS(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    cla_multiword_add_seq #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // External adder models.
    assign {bus.add_cout, bus.add_sum} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};
    assign {bus1.add_cout, bus1.add_sum} =
        {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {16'd0, bus1.add_cin};

    int total = 0;
    int bad   = 0;
    logic [3:0] cin_log;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request on the WORDS=4 instance; returns result and the number
    // of clock edges from the accept edge until out_valid is seen.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub,
                         output logic [63:0] s, output logic co, output logic ov,
                         output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after accept; they must not affect the result.
        bus.in_valid = 1'b0;
        bus.in_a = ~a; bus.in_b = ~b; bus.in_cin = ~cin; bus.in_sub = ~sub;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (lat < 4) cin_log[lat] = bus.add_cin;
            @(posedge clk); #1;
            lat++;
        end
        s  = bus.out_sum;
        co = bus.out_cout;
        ov = bus.out_ovf;
    endtask

    task automatic finish_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after_consume", 64'(bus.in_ready), 64'd1);
        chk("out_valid_after_consume", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic do_op1(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        bus1.in_a = a; bus1.in_b = b; bus1.in_cin = 1'b0; bus1.in_sub = 1'b0;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus1.in_a = ~a;
        lat = 0;
        while (!bus1.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w1_latency", 64'(lat), 64'd1);
        chk("w1_sum",  64'(bus1.out_sum), 64'(es));
        chk("w1_cout", 64'(bus1.out_cout), 64'(ec));
        chk("w1_ovf",  64'(bus1.out_ovf), 64'(eo));
        @(negedge clk);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("w1_in_ready_after", 64'(bus1.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] s;
        logic co, ov;
        int lat;
        logic stayed_low;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[6] = '{64'h10, 64'h1, 1'b1, 1'b1, 64'hE, 1'b1, 1'b0};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 64'h2222_2222_2222_2212, 1'b0, 1'b0};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.in_sub = 0;
        bus.abort = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 0; bus1.in_sub = 0;
        bus1.abort = 0; bus1.out_ready = 0;
        cin_log = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum",   bus.out_sum, 64'd0);
        chk("rst_out_cout",  64'(bus.out_cout), 64'd0);
        chk("rst_out_ovf",   64'(bus.out_ovf), 64'd0);
        chk("rst_add_a",     64'(bus.add_a), 64'd0);
        chk("rst_add_cin",   64'(bus.add_cin), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("v%0d_sum", i),  s, vecs[i].sum);
            chk($sformatf("v%0d_cout", i), 64'(co), 64'(vecs[i].cout));
            chk($sformatf("v%0d_ovf", i),  64'(ov), 64'(vecs[i].ovf));
            if (i == 1) chk("ripple_slice_cins", 64'(cin_log), 64'hF);
            finish_op();
        end

        // Backpressure: result held for 10 cycles with out_ready low.
        do_op(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, s, co, ov, lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
            chk($sformatf("bp%0d_sum", c), bus.out_sum, vecs[0].sum);
        end
        chk("bp_add_a_done", 64'(bus.add_a), 64'd0);
        finish_op();

        // Abort during slice 2.
        @(negedge clk);
        bus.in_a = vecs[7].a; bus.in_b = vecs[7].b; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_slice2_add_a", 64'(bus.add_a), 64'h5678);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        stayed_low = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) stayed_low = 1'b0;
        end
        chk("abort_no_out_valid", 64'(stayed_low), 64'd1);

        // Abort together with a request in IDLE: request is accepted.
        @(negedge clk);
        bus.in_a = vecs[3].a; bus.in_b = vecs[3].b; bus.in_cin = 1'b0; bus.in_sub = 1'b1;
        bus.in_valid = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.abort = 1'b0;
        chk("idle_abort_accepted", 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("idle_abort_latency", 64'(lat), 64'd4);
        chk("idle_abort_sum", bus.out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("idle_abort_cout", 64'(bus.out_cout), 64'd0);
        finish_op();

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.in_a = vecs[7].a; bus.in_b = vecs[7].b; bus.in_cin = 1'b1; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_sum",   bus.out_sum, 64'd0);
        chk("arst_out_cout",  64'(bus.out_cout), 64'd0);
        chk("arst_add_a",     64'(bus.add_a), 64'd0);
        chk("arst_add_cin",   64'(bus.add_cin), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, s, co, ov, lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_sum", s, vecs[0].sum);
        chk("post_rst_cout", 64'(co), 64'd0);
        finish_op();

        // WORDS=1 instance.
        do_op1(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        do_op1(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
